// File: rtl/div_seq.sv
// Sequential radix-2 restoring divider: one quotient bit per clock, start/busy/done
// handshake, registered results, optional two's-complement mode, defined divide-by-zero.
module div_seq #(
  parameter int DW        = 26,
  parameter int VW        = 9,
  parameter int SIGNED_EN = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          signed_mode,
  input  logic [DW-1:0] did,
  input  logic [VW-1:0] div,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quo,
  output logic [VW-1:0] rem,
  output logic          error
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dreg;   // dividend bits shift out the top, quotient bits shift in the bottom
  logic [VW-1:0] dvs;
  logic [VW:0]   prem;
  logic          qneg, rneg;

  logic          sm, did_neg, div_neg, div_zero;
  logic [DW-1:0] did_mag;
  logic [VW-1:0] div_mag;
  logic [VW:0]   prem_sh, prem_nx;
  logic          ge;

  assign sm       = (SIGNED_EN != 0) && signed_mode;
  assign did_neg  = sm & did[DW-1];
  assign div_neg  = sm & div[VW-1];
  // The most negative value negates to itself, which reads correctly as an unsigned magnitude.
  assign did_mag  = did_neg ? -did : did;
  assign div_mag  = div_neg ? -div : div;
  assign div_zero = (div == '0);

  assign prem_sh  = {prem[VW-1:0], dreg[DW-1]};
  assign ge       = (prem_sh >= {1'b0, dvs});
  assign prem_nx  = ge ? (prem_sh - {1'b0, dvs}) : prem_sh;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: next-state gets its default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = div_zero ? DONE : CALC;
      CALC:    if (cnt == CW'(1)) state_nx = FIX;
      FIX:     state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: datapath registers are reset too, so an aborted operation leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      dreg  <= '0;
      dvs   <= '0;
      prem  <= '0;
      qneg  <= 1'b0;
      rneg  <= 1'b0;
      quo   <= '0;
      rem   <= '0;
      error <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            if (div_zero) begin
              quo   <= '1;
              rem   <= '0;
              error <= 1'b1;
            end else begin
              dreg <= did_mag;
              dvs  <= div_mag;
              prem <= '0;
              qneg <= did_neg ^ div_neg;
              rneg <= did_neg;
              cnt  <= CW'(DW);
            end
          end
        end
        CALC: begin
          prem <= prem_nx;
          dreg <= {dreg[DW-2:0], ge};
          cnt  <= cnt - CW'(1);
        end
        FIX: begin
          // The final partial remainder is below |div|, so it fits the VW-bit field.
          quo   <= qneg ? -dreg : dreg;
          rem   <= rneg ? -prem[VW-1:0] : prem[VW-1:0];
          error <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: stimulus pushes expected results, a monitor pops them on done
// and also checks latency and that results hold steady while busy.
module tb_div_seq;

  localparam int DW = 26;
  localparam int VW = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          signed_mode = 1'b0;
  logic [DW-1:0] did = '0;
  logic [VW-1:0] div = '0;
  logic          busy, done, error;
  logic [DW-1:0] quo;
  logic [VW-1:0] rem;

  div_seq #(.DW(DW), .VW(VW), .SIGNED_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .did(did), .div(div), .busy(busy), .done(done),
    .quo(quo), .rem(rem), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          e;
    int            start_cyc;
    int            lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   ndone = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard pop on done, plus hold check on results while busy.
  logic          prev_busy = 1'b0;
  logic [DW-1:0] prev_quo;
  logic [VW-1:0] prev_rem;
  logic          prev_err;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      ndone++;
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("quo", quo, e.q);
        check("rem", rem, e.r);
        check("error", error, e.e);
        check("latency", cyc - e.start_cyc, e.lat);
      end
    end
    if (rst_n && prev_busy && busy && !done) begin
      check("quo_hold", quo, prev_quo);
      check("rem_hold", rem, prev_rem);
      check("err_hold", error, prev_err);
    end
    prev_busy = busy && rst_n;
    prev_quo  = quo;
    prev_rem  = rem;
    prev_err  = error;
  end

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    check("idle_timeout", busy, 0);
  endtask

  task automatic run_op(input logic [DW-1:0] d, input logic [VW-1:0] v, input logic sm,
                        input logic [DW-1:0] eq, input logic [VW-1:0] er, input logic ee);
    exp_t e;
    @(negedge clk);
    did = d; div = v; signed_mode = sm; start = 1'b1;
    e.q = eq; e.r = er; e.e = ee; e.start_cyc = cyc;
    e.lat = (v == '0) ? 1 : DW + 2;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", busy, 1);
    // Scramble operands after acceptance; the result must not move.
    did = ~d; div = v + 9'd1; signed_mode = ~sm;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    int            next_free, n_acc, done0;
    logic [DW-1:0] d;
    logic [VW-1:0] v;
    exp_t          e;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quo", quo, 0);
    check("rst_rem", rem, 0);
    check("rst_error", error, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Unsigned and divide-by-zero.
    run_op(26'd1000, 9'd7, 1'b0, 26'd142, 9'd6, 1'b0);
    run_op(26'd55,   9'd0, 1'b0, 26'h3FFFFFF, 9'd0, 1'b1);
    run_op(26'd55,   9'd5, 1'b0, 26'd11, 9'd0, 1'b0);

    // Signed: truncation toward zero, remainder follows the dividend.
    run_op(-26'd100, 9'd7,  1'b1, -26'd14, -9'd2, 1'b0);
    run_op(26'd100,  -9'd7, 1'b1, -26'd14, 9'd2,  1'b0);
    run_op(-26'd7,   9'd2,  1'b1, -26'd3,  -9'd1, 1'b0);
    run_op(26'h2000000, 9'h1FF, 1'b1, 26'h2000000, 9'd0, 1'b0);

    // Unsigned extremes.
    run_op(26'h3FFFFFF, 9'd1,   1'b0, 26'h3FFFFFF, 9'd0, 1'b0);
    run_op(26'd5,       9'h1FF, 1'b0, 26'd0, 9'd5, 1'b0);
    run_op(26'd0,       9'd3,   1'b0, 26'd0, 9'd0, 1'b0);

    // start held high with changing operands: accepts only in IDLE, once per DW+3 cycles.
    next_free = 0; n_acc = 0; done0 = ndone;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      d = 26'(1000 + i * 37);
      v = 9'(3 + i);
      did = d; div = v; signed_mode = 1'b0; start = 1'b1;
      if (i == next_free) begin
        e.q = d / DW'(v); e.r = VW'(d % DW'(v)); e.e = 1'b0;
        e.start_cyc = cyc; e.lat = DW + 2;
        sb.push_back(e);
        next_free = i + DW + 3;
        n_acc++;
      end
    end
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    check("dones_per_accept", ndone - done0, n_acc);
    check("sb_empty", sb.size(), 0);

    // Asynchronous reset in the middle of CALC aborts without a done pulse.
    @(negedge clk);
    did = 26'd1000; div = 9'd7; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_quo", quo, 0);
    check("arst_rem", rem, 0);
    check("arst_error", error, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", busy, 0);
    run_op(26'd1000, 9'd7, 1'b0, 26'd142, 9'd6, 1'b0);
    check("sb_empty_end", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
